// File: rtl/cpu_edu_pkg.sv
// Shared constants and fetch-state encoding for the instruction prefetch path.
package cpu_edu_pkg;
    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 14;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        FQ_IDLE    = 2'd0,
        FQ_WAIT    = 2'd1,
        FQ_DISCARD = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/instr_fetch_queue_if.sv
// Memory fetch port, redirect input and decode-side handshake of the prefetch queue.
interface instr_fetch_queue_if
    import cpu_edu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = ADDR_W,
    parameter int DW    = INSTR_W
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          redirect;
    logic [AW-1:0] redirect_addr;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic [CW-1:0] count;

    modport master (
        output mem_req, mem_addr, instr, instr_pc, instr_valid, count,
        input  mem_ack, mem_rvalid, mem_rdata, redirect, redirect_addr, instr_ready
    );

    modport slave (
        input  mem_req, mem_addr, instr, instr_pc, instr_valid, count,
        output mem_ack, mem_rvalid, mem_rdata, redirect, redirect_addr, instr_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Circular buffer holding {instruction, pc} entries with synchronous clear.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 30
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL  = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_1 = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_1 = PW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push && (count != FULL);
    assign pop_ok  = pop && (count != '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_1;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_1;
            if (push_ok && !pop_ok)      count <= count + CNT_1;
            else if (pop_ok && !push_ok) count <= count - CNT_1;
        end
    end

    // Storage needs no reset: empty entries are never presented downstream.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/instr_fetch_queue.sv
// Prefetch queue: sequential fetches over a valid/ack port, buffered for decode, flushed on redirect.
//   state      | meaning
//   FQ_IDLE    | no request outstanding
//   FQ_WAIT    | request accepted, response pending
//   FQ_DISCARD | in-flight request is stale; its response is dropped
module instr_fetch_queue
    import cpu_edu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = ADDR_W,
    parameter int DW    = INSTR_W
) (
    input  logic clk,
    input  logic reset,
    instr_fetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [AW-1:0]     fetch_pc;
    logic [AW-1:0]     req_pc;
    logic [CW-1:0]     occ;
    logic [DW+AW-1:0]  head;
    logic              have_head;
    logic              accept;
    logic              push;
    logic              pop;

    assign have_head = (occ != '0);
    // Requests only issue while a slot is guaranteed for the response.
    assign bus.mem_req  = reset && (state_q == FQ_IDLE) && !bus.redirect && (occ < FULL);
    assign bus.mem_addr = fetch_pc;
    assign accept       = bus.mem_req && bus.mem_ack;
    assign push         = (state_q == FQ_WAIT) && bus.mem_rvalid && !bus.redirect;
    assign pop          = have_head && bus.instr_ready && !bus.redirect;

    assign bus.instr_valid = have_head;
    assign bus.instr       = have_head ? head[DW+AW-1:AW] : DW'(NOP_INSTR);
    assign bus.instr_pc    = have_head ? head[AW-1:0] : '0;
    assign bus.count       = occ;

    fetch_fifo #(.DEPTH(DEPTH), .W(DW+AW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (bus.redirect),
        .push  (push),
        .pop   (pop),
        .wdata ({bus.mem_rdata, req_pc}),
        .rdata (head),
        .count (occ)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FQ_IDLE:    if (accept) state_d = FQ_WAIT;
            FQ_WAIT: begin
                if (bus.mem_rvalid)    state_d = FQ_IDLE;
                else if (bus.redirect) state_d = FQ_DISCARD;
            end
            FQ_DISCARD: if (bus.mem_rvalid) state_d = FQ_IDLE;
            default:    state_d = FQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= FQ_IDLE;
            fetch_pc <= '0;
            req_pc   <= '0;
        end else begin
            state_q <= state_d;
            if (bus.redirect)  fetch_pc <= bus.redirect_addr;
            else if (accept)   fetch_pc <= fetch_pc + AW'(1);
            if (accept)        req_pc   <= fetch_pc;
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench: a memory responder feeds tagged fetches, a monitor compares the decode-side head.
module tb_instr_fetch_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 14;
    localparam int DW    = 16;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [AW-1:0] pc;
    } ent_t;

    logic clk = 1'b0;
    logic reset;

    instr_fetch_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    instr_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    ent_t          exp_q[$];
    int            epoch = 0;
    logic [AW-1:0] exp_fetch_pc = '0;
    int            ack_block = 0;
    logic          stall_rv = 1'b0;
    logic          sb_push = 1'b0;
    ent_t          sb_ent;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        return {a, 2'b10} ^ 16'h5A3C;
    endfunction

    // Memory model: acks per ack_block, returns data one cycle after accept unless stalled.
    initial begin
        logic          acc_now;
        logic [AW-1:0] acc_addr;
        int            acc_ep;
        logic          pend;
        logic [AW-1:0] pend_addr;
        int            pend_ep;
        pend = 1'b0;
        pend_addr = '0;
        pend_ep = 0;
        acc_addr = '0;
        acc_ep = 0;
        bus.mem_ack = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            acc_now = bus.mem_req && bus.mem_ack && reset;
            if (acc_now) begin
                chk("mem_addr", 32'(bus.mem_addr), 32'(exp_fetch_pc));
                acc_addr = exp_fetch_pc;
                acc_ep = epoch;
                exp_fetch_pc = exp_fetch_pc + 14'd1;
            end
            @(posedge clk);
            #2;
            bus.mem_rvalid = 1'b0;
            sb_push = 1'b0;
            if (acc_now) begin
                pend = 1'b1;
                pend_addr = acc_addr;
                pend_ep = acc_ep;
            end
            if (pend && !stall_rv) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata = rom(pend_addr);
                pend = 1'b0;
                if (pend_ep == epoch) begin
                    sb_push = 1'b1;
                    sb_ent = '{d: rom(pend_addr), pc: pend_addr};
                end
            end
            if (ack_block > 0) begin
                bus.mem_ack = 1'b0;
                ack_block--;
            end else begin
                bus.mem_ack = 1'b1;
            end
        end
    end

    // Monitor: compare head against the scoreboard, then apply the coming edge to it.
    always @(negedge clk) begin
        if (reset) begin
            chk("count", 32'(bus.count), 32'(exp_q.size()));
            if (exp_q.size() > 0) begin
                chk("instr_valid", 32'(bus.instr_valid), 32'd1);
                chk("instr", 32'(bus.instr), 32'(exp_q[0].d));
                chk("instr_pc", 32'(bus.instr_pc), 32'(exp_q[0].pc));
            end else begin
                chk("instr_valid_e", 32'(bus.instr_valid), 32'd0);
                chk("instr_e", 32'(bus.instr), 32'd0);
                chk("instr_pc_e", 32'(bus.instr_pc), 32'd0);
            end
            if (bus.redirect) begin
                exp_q.delete();
            end else begin
                if (exp_q.size() > 0 && bus.instr_ready) void'(exp_q.pop_front());
                if (sb_push) exp_q.push_back(sb_ent);
            end
        end
    end

    task automatic wait_cnt(input int n, input int lim);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (32'(bus.count) != n && k < lim);
        chk("wait_count", 32'(bus.count), 32'(n));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_addr = '0;
        bus.instr_ready = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_instr", 32'(bus.instr), 32'd0);
        chk("rst_instr_pc", 32'(bus.instr_pc), 32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);

        // Fill to DEPTH with decode stalled
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("first_req", 32'(bus.mem_req), 32'd1);
        chk("first_addr", 32'(bus.mem_addr), 32'd0);
        repeat (2) @(negedge clk);
        chk("latency_valid", 32'(bus.instr_valid), 32'd1);
        wait_cnt(4, 40);
        repeat (3) begin
            @(negedge clk);
            chk("full_no_req", 32'(bus.mem_req), 32'd0);
        end
        chk("full_head", 32'(bus.instr), 32'(rom(14'd0)));
        chk("full_head_pc", 32'(bus.instr_pc), 32'd0);

        // Single pop frees a slot
        tick();
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        @(negedge clk);
        chk("pop_count", 32'(bus.count), 32'd3);
        chk("pop_head", 32'(bus.instr), 32'(rom(14'd1)));
        chk("refill_req", 32'(bus.mem_req), 32'd1);
        chk("refill_addr", 32'(bus.mem_addr), 32'd4);

        // Redirect while WAIT; stale response must be dropped
        tick();
        stall_rv = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_addr = 14'h0100;
        epoch++;
        exp_fetch_pc = 14'h0100;
        @(negedge clk);
        chk("redir_req_low", 32'(bus.mem_req), 32'd0);
        tick();
        bus.redirect = 1'b0;
        @(negedge clk);
        chk("flush_count", 32'(bus.count), 32'd0);
        chk("flush_valid", 32'(bus.instr_valid), 32'd0);
        chk("flush_instr", 32'(bus.instr), 32'd0);
        chk("discard_no_req", 32'(bus.mem_req), 32'd0);
        tick();
        stall_rv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("redir_req", 32'(bus.mem_req), 32'd1);
        chk("redir_addr", 32'(bus.mem_addr), 32'h0100);
        wait_cnt(1, 20);
        chk("redir_pc", 32'(bus.instr_pc), 32'h0100);
        wait_cnt(4, 30);

        // Address wrap at the top of the space
        tick();
        bus.redirect = 1'b1;
        bus.redirect_addr = 14'h3FFF;
        epoch++;
        exp_fetch_pc = 14'h3FFF;
        tick();
        bus.redirect = 1'b0;
        wait_cnt(1, 20);
        chk("wrap_pc", 32'(bus.instr_pc), 32'h3FFF);
        chk("wrap_req", 32'(bus.mem_req), 32'd1);
        chk("wrap_addr", 32'(bus.mem_addr), 32'h0000);
        wait_cnt(4, 30);

        // Ack withheld for 3 request cycles
        tick();
        ack_block = 4;
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("hold_req", 32'(bus.mem_req), 32'd1);
            chk("hold_addr", 32'(bus.mem_addr), 32'd3);
            chk("hold_ack", 32'(bus.mem_ack), 32'd0);
        end
        @(negedge clk);
        chk("hold_final_addr", 32'(bus.mem_addr), 32'd3);
        @(negedge clk);
        chk("hold_wait_req", 32'(bus.mem_req), 32'd0);
        @(negedge clk);
        chk("hold_push", 32'(bus.count), 32'd4);

        // Reset during WAIT; late response must not push
        tick();
        stall_rv = 1'b1;
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        tick();
        reset = 1'b0;
        epoch++;
        exp_q.delete();
        exp_fetch_pc = '0;
        ack_block = 100;
        @(negedge clk);
        chk("midrst_count", 32'(bus.count), 32'd0);
        chk("midrst_req", 32'(bus.mem_req), 32'd0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_req", 32'(bus.mem_req), 32'd1);
        chk("post_rst_addr", 32'(bus.mem_addr), 32'd0);
        tick();
        stall_rv = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("stale_no_push", 32'(bus.count), 32'd0);
        end
        tick();
        ack_block = 0;
        wait_cnt(4, 40);
        chk("restart_pc", 32'(bus.instr_pc), 32'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
